// File: rtl/kv_response_builder_pkg.sv
// kv_pkg: shared constants, field offsets, types and helpers for the KV response builder
package kv_pkg;
    localparam int DATA_WIDTH      = 512;
    localparam int KEEP_W          = DATA_WIDTH / 8;
    localparam int PTR_WIDTH       = 16;
    localparam int MAX_BEATS       = 64;
    localparam int MAX_OUTSTANDING = 4;
    localparam int RESULT_W        = 105;

    localparam int RES_KEY_LSB = 0;
    localparam int RES_LEN_LSB = 64;
    localparam int RES_PTR_LSB = 80;
    localparam int RES_HIT_BIT = 96;
    localparam int RES_OP_LSB  = 97;

    localparam int HDR_KEY_LSB    = 0;
    localparam int HDR_LEN_LSB    = 64;
    localparam int HDR_OP_LSB     = 80;
    localparam int HDR_STATUS_LSB = 88;
    localparam int HDR_TS_LSB     = 96;

    localparam logic [7:0] OP_GET = 8'd0;
    localparam logic [7:0] OP_SET = 8'd1;
    localparam logic [7:0] OP_DEL = 8'd2;

    typedef enum logic [7:0] {STAT_OK = 8'd0, STAT_MISS = 8'd1, STAT_TOOBIG = 8'd2} status_t;
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_FREE} state_t;

    // Byte-enable mask for the final value beat; a zero remainder means a full beat.
    function automatic logic [KEEP_W-1:0] keep_from_rem(input logic [5:0] rem);
        return rem == 6'd0 ? '1 : (KEEP_W'(1) << rem) - KEEP_W'(1);
    endfunction
endpackage

// File: rtl/kv_response_builder_if.sv
// kv_response_builder_if: result, value-memory read, response stream and free-pointer buses
interface kv_response_builder_if;
    import kv_pkg::*;
    logic [RESULT_W-1:0]   s_result_data;
    logic                  s_result_valid;
    logic                  s_result_ready;
    logic [PTR_WIDTH-1:0]  m_rd_addr;
    logic                  m_rd_valid;
    logic                  m_rd_ready;
    logic [DATA_WIDTH-1:0] s_rd_data;
    logic                  s_rd_valid;
    logic                  s_rd_ready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic [KEEP_W-1:0]     m_axis_tkeep;
    logic                  m_axis_tready;
    logic [PTR_WIDTH-1:0]  m_free_pointer;
    logic                  m_free_pointer_valid;
    logic                  m_free_pointer_ready;

    modport slave (
        input  s_result_data, s_result_valid, m_rd_ready, s_rd_data, s_rd_valid,
               m_axis_tready, m_free_pointer_ready,
        output s_result_ready, m_rd_addr, m_rd_valid, s_rd_ready, m_axis_tdata,
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_free_pointer, m_free_pointer_valid
    );

    modport master (
        output s_result_data, s_result_valid, m_rd_ready, s_rd_data, s_rd_valid,
               m_axis_tready, m_free_pointer_ready,
        input  s_result_ready, m_rd_addr, m_rd_valid, s_rd_ready, m_axis_tdata,
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_free_pointer, m_free_pointer_valid
    );
endinterface

// File: rtl/kv_response_builder_fifo.sv
// fifo: first-word-fall-through synchronous FIFO, power-of-two depth
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pull;

    assign wr_ready = count != (AW+1)'(DEPTH);
    assign rd_valid = count != '0;
    assign rd_data  = mem[rd_ptr];
    assign push     = wr_valid && wr_ready;
    assign pull     = rd_valid && rd_ready;

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pull) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pull);
        end
    end
endmodule

// File: rtl/kv_response_builder.sv
// kv_response_builder: builds UDP KV response packets; KV_RESP_TIMESTAMP_EN adds a header timestamp
module kv_response_builder
    import kv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    kv_response_builder_if.slave bus
);
`ifdef KV_RESP_TIMESTAMP_EN
    localparam logic [KEEP_W-1:0] HDR_ONLY_KEEP = 64'hFFFF;
`else
    localparam logic [KEEP_W-1:0] HDR_ONLY_KEEP = 64'h0FFF;
`endif
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] hdr;
    logic                  hdr_last;
    logic                  has_data;
    logic                  do_free;
    logic [PTR_WIDTH-1:0]  ptr;
    logic [5:0]            rem;
    logic [16:0]           nbeats;
    logic [16:0]           issued;
    logic [16:0]           sent;
    logic [CW-1:0]         credits;

    logic [7:0]            r_op;
    logic                  r_hit;
    logic [PTR_WIDTH-1:0]  r_ptr;
    logic [15:0]           r_len;
    logic [63:0]           r_key;
    logic [16:0]           r_nbeats;
    logic                  r_get_hit;
    logic                  r_toobig;
    logic                  r_has_data;
    status_t               r_status;
    logic [DATA_WIDTH-1:0] r_hdr;
    logic [31:0]           ts_now;

    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_valid;
    logic                  fifo_wr_ready;
    logic                  rd_valid;
    logic                  rd_fire;
    logic                  beat_valid;
    logic                  pop;
    logic                  data_last;

`ifdef KV_RESP_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    // Free-running cycle counter sampled into the header at result accept.
    always_ff @(posedge clk) begin
        cycle_cnt <= rst ? 32'd0 : cycle_cnt + 32'd1;
    end

    assign ts_now = cycle_cnt;
`else
    assign ts_now = 32'd0;
`endif

    assign r_op       = bus.s_result_data[RES_OP_LSB +: 8];
    assign r_hit      = bus.s_result_data[RES_HIT_BIT];
    assign r_ptr      = bus.s_result_data[RES_PTR_LSB +: PTR_WIDTH];
    assign r_len      = bus.s_result_data[RES_LEN_LSB +: 16];
    assign r_key      = bus.s_result_data[RES_KEY_LSB +: 64];
    assign r_nbeats   = (17'(r_len) + 17'd63) >> 6;
    assign r_get_hit  = r_op == OP_GET && r_hit;
    assign r_toobig   = r_get_hit && r_nbeats > 17'(MAX_BEATS);
    assign r_has_data = r_get_hit && !r_toobig && r_nbeats != 17'd0;
    assign r_status   = !r_hit ? STAT_MISS : (r_toobig ? STAT_TOOBIG : STAT_OK);

    // Header beat assembled from the incoming result; length is only reported for GET hits.
    always_comb begin
        r_hdr = '0;
        r_hdr[HDR_KEY_LSB +: 64]   = r_key;
        r_hdr[HDR_LEN_LSB +: 16]   = r_get_hit ? r_len : 16'd0;
        r_hdr[HDR_OP_LSB +: 8]     = r_op;
        r_hdr[HDR_STATUS_LSB +: 8] = r_status;
        r_hdr[HDR_TS_LSB +: 32]    = ts_now;
    end

    fifo #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (bus.s_rd_data),
        .wr_valid (bus.s_rd_valid),
        .wr_ready (fifo_wr_ready),
        .rd_data  (fifo_data),
        .rd_valid (fifo_valid),
        .rd_ready (pop)
    );

    assign rd_valid   = state == ST_DATA && issued < nbeats && credits != '0;
    assign rd_fire    = rd_valid && bus.m_rd_ready;
    assign beat_valid = state == ST_DATA && fifo_valid;
    assign pop        = beat_valid && bus.m_axis_tready;
    assign data_last  = sent == nbeats - 17'd1;

    assign bus.s_result_ready       = state == ST_IDLE;
    assign bus.s_rd_ready           = fifo_wr_ready;
    assign bus.m_rd_valid           = rd_valid;
    assign bus.m_rd_addr            = rd_valid ? ptr + issued[PTR_WIDTH-1:0] : '0;
    assign bus.m_axis_tvalid        = state == ST_HDR || beat_valid;
    assign bus.m_axis_tdata         = state == ST_HDR ? hdr : (beat_valid ? fifo_data : '0);
    assign bus.m_axis_tlast         = state == ST_HDR ? hdr_last : beat_valid && data_last;
    assign bus.m_axis_tkeep         = state == ST_HDR ? (hdr_last ? HDR_ONLY_KEEP : '1) :
                                      beat_valid ? (data_last ? keep_from_rem(rem) : '1) : '0;
    assign bus.m_free_pointer_valid = state == ST_FREE;
    assign bus.m_free_pointer       = state == ST_FREE ? ptr : '0;

    // Packet sequencing, read issue bookkeeping and read credits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hdr      <= '0;
            hdr_last <= 1'b0;
            has_data <= 1'b0;
            do_free  <= 1'b0;
            ptr      <= '0;
            rem      <= '0;
            nbeats   <= '0;
            issued   <= '0;
            sent     <= '0;
            credits  <= CW'(MAX_OUTSTANDING);
        end else begin
            credits <= credits - CW'(rd_fire) + CW'(pop);
            case (state)
                ST_IDLE: if (bus.s_result_valid) begin
                    hdr      <= r_hdr;
                    hdr_last <= !r_has_data;
                    has_data <= r_has_data;
                    do_free  <= r_op == OP_DEL && r_hit;
                    ptr      <= r_ptr;
                    rem      <= r_len[5:0];
                    nbeats   <= r_nbeats;
                    state    <= ST_HDR;
                end
                ST_HDR: if (bus.m_axis_tready) begin
                    issued <= '0;
                    sent   <= '0;
                    state  <= has_data ? ST_DATA : (do_free ? ST_FREE : ST_IDLE);
                end
                ST_DATA: begin
                    if (rd_fire) issued <= issued + 17'd1;
                    if (pop) begin
                        sent <= sent + 17'd1;
                        if (data_last) state <= ST_IDLE;
                    end
                end
                ST_FREE: if (bus.m_free_pointer_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kv_response_builder.sv
// tb_kv_response_builder: randomized self-checking bench against a packet-level reference model
module tb_kv_response_builder;
    import kv_pkg::*;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        bit           val;
        bit           rdn;
    } beat_t;

`ifdef KV_RESP_TIMESTAMP_EN
    localparam logic [63:0] HK = 64'hFFFF;
`else
    localparam logic [63:0] HK = 64'h0FFF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    kv_response_builder_if bus();

    kv_response_builder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    beat_t exp_beats[$];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_free[$];
    logic [15:0] pend[$];
    int outstanding = 0;
    int val_seen = 0;
    int free_hold = 0;
    int tmode = 0;
    bit accepted, hdr_due, rd_due, rd_hold, stall_prev;
    logic [511:0] prev_d;
    logic [63:0]  prev_k;
    logic         prev_l;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value memory contents: every box is a distinct, address-derived pattern.
    function automatic logic [511:0] mem_word(input logic [15:0] a);
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = {a, 8'(i), a[7:0] ^ 8'h5A};
        return w;
    endfunction

    // Reference model: turns one accepted result into the full expected response.
    task automatic model_accept(input logic [104:0] r);
        logic [7:0]   op = r[104:97];
        logic         hit = r[96];
        logic [15:0]  p = r[95:80];
        logic [15:0]  len = r[79:64];
        int           nb = (int'(len) + 63) / 64;
        int           rm = int'(len) % 64;
        bit           gh = op == 8'd0 && hit;
        bit           big = gh && nb > 64;
        int           nv = (gh && !big) ? nb : 0;
        beat_t        b;
        logic [15:0]  a;
        b.d = '0;
        b.d[63:0]  = r[63:0];
        b.d[79:64] = gh ? len : 16'd0;
        b.d[87:80] = op;
        b.d[95:88] = !hit ? 8'd1 : (big ? 8'd2 : 8'd0);
        b.k   = nv == 0 ? HK : '1;
        b.l   = nv == 0;
        b.val = 0;
        b.rdn = nv > 0;
        exp_beats.push_back(b);
        for (int i = 0; i < nv; i++) begin
            a = p + 16'(i);
            exp_rd.push_back(a);
            b.d   = mem_word(a);
            b.val = 1;
            b.rdn = 0;
            b.l   = i == nv - 1;
            for (int j = 0; j < 64; j++) b.k[j] = !b.l || rm == 0 || j < rm;
            exp_beats.push_back(b);
        end
        if (op == 8'd2 && hit) exp_free.push_back(p);
    endtask

    task automatic sample();
        beat_t e;
        logic [511:0] od;
        string t;
        if (hdr_due) check("hdr_latency", bus.m_axis_tvalid, 1'b1);
        if (rd_due) check("rd_latency", bus.m_rd_valid, 1'b1);
        hdr_due = 0;
        rd_due  = 0;
        if (stall_prev) begin
            check("hold_valid", bus.m_axis_tvalid, 1'b1);
            check("hold_data", bus.m_axis_tdata, prev_d);
            check("hold_keep_last", {bus.m_axis_tlast, bus.m_axis_tkeep}, {prev_l, prev_k});
        end
        if (bus.s_result_valid && bus.s_result_ready) begin
            model_accept(bus.s_result_data);
            accepted = 1;
            hdr_due  = 1;
        end
        if (bus.m_rd_valid && bus.m_rd_ready) begin
            if (exp_rd.size() == 0) check("rd_unexpected", {1'b1, bus.m_rd_addr}, 17'h0);
            else check("rd_addr", bus.m_rd_addr, exp_rd.pop_front());
            pend.push_back(bus.m_rd_addr);
            outstanding++;
            check("outstanding_le_4", outstanding <= MAX_OUTSTANDING, 1'b1);
        end
        if (bus.s_rd_valid && bus.s_rd_ready) begin
            void'(pend.pop_front());
            rd_hold = 0;
        end else rd_hold = bus.s_rd_valid;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (exp_beats.size() == 0) check("beat_unexpected", 1'b1, 1'b0);
            else begin
                e = exp_beats.pop_front();
                od = bus.m_axis_tdata;
`ifdef KV_RESP_TIMESTAMP_EN
                if (!e.val) od[127:96] = '0;
`endif
                t = e.val ? "val" : "hdr";
                check({t, "_data"}, od, e.d);
                check({t, "_keep"}, bus.m_axis_tkeep, e.k);
                check({t, "_last"}, bus.m_axis_tlast, e.l);
                if (e.val) begin
                    outstanding--;
                    val_seen++;
                end
                rd_due = e.rdn;
            end
        end
        stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_d = bus.m_axis_tdata;
        prev_k = bus.m_axis_tkeep;
        prev_l = bus.m_axis_tlast;
        if (bus.m_free_pointer_valid) begin
            check("busy_during_free", bus.s_result_ready, 1'b0);
            if (bus.m_free_pointer_ready) begin
                if (exp_free.size() == 0) check("free_unexpected", 1'b1, 1'b0);
                else check("free_ptr", bus.m_free_pointer, exp_free.pop_front());
            end
            if (free_hold > 0) free_hold--;
        end
    endtask

    // Sink/memory side: drive ready/data at the falling edge, then sample the cycle.
    initial forever begin
        @(negedge clk);
        bus.m_axis_tready = tmode == 0 ? 1'b1 : tmode == 1 ? ~bus.m_axis_tready : 1'($urandom_range(0, 2) != 0);
        bus.m_rd_ready = $urandom_range(0, 3) != 0;
        bus.m_free_pointer_ready = free_hold == 0 && $urandom_range(0, 2) != 0;
        bus.s_rd_valid = pend.size() > 0 && (rd_hold || $urandom_range(0, 2) != 0);
        if (bus.s_rd_valid) bus.s_rd_data = mem_word(pend[0]);
        else bus.s_rd_data = '0;
        #1;
        if (!rst) sample();
    end

    task automatic clear_model();
        exp_beats.delete();
        exp_rd.delete();
        exp_free.delete();
        pend.delete();
        outstanding = 0;
        rd_hold = 0;
        hdr_due = 0;
        rd_due = 0;
        stall_prev = 0;
    endtask

    task automatic send(input logic [7:0] op, input bit hit, input logic [15:0] p,
                        input logic [15:0] len, input logic [63:0] key);
        int n = 0;
        @(negedge clk);
        bus.s_result_data  = {op, hit, p, len, key};
        bus.s_result_valid = 1'b1;
        accepted = 0;
        while (!accepted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        bus.s_result_valid = 1'b0;
        check("accept_timeout", accepted, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_beats.size() != 0 || exp_free.size() != 0 || !bus.s_result_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 3000, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.s_result_valid = 1'b0;
        bus.s_result_data = '0;
        bus.m_axis_tready = 1'b1;
        bus.m_rd_ready = 1'b0;
        bus.s_rd_valid = 1'b0;
        bus.s_rd_data = '0;
        bus.m_free_pointer_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_tvalid", bus.m_axis_tvalid, 1'b0);
        check("rst_tdata", bus.m_axis_tdata, '0);
        check("rst_tkeep_tlast", {bus.m_axis_tlast, bus.m_axis_tkeep}, '0);
        check("rst_rd", {bus.m_rd_valid, bus.m_rd_addr}, '0);
        check("rst_free", {bus.m_free_pointer_valid, bus.m_free_pointer}, '0);
        check("rst_result_ready", bus.s_result_ready, 1'b1);
        rst = 1'b0;

        tmode = 0;
        send(OP_GET, 1, 16'h0010, 16'd130, 64'h1122_3344_5566_7788);
        wait_idle();
        send(OP_GET, 0, 16'h0077, 16'd100, 64'hDEAD_BEEF);
        wait_idle();
        tmode = 2;
        free_hold = 5;
        send(OP_DEL, 1, 16'h0042, 16'd0, 64'hABCD);
        wait_idle();
        check("free_hold_used", free_hold, 0);
        tmode = 1;
        send(OP_GET, 1, 16'h0200, 16'd4096, 64'h4096);
        wait_idle();
        send(OP_GET, 1, 16'h0300, 16'd4097, 64'h4097);
        send(OP_GET, 1, 16'h0301, 16'd0, 64'h0);
        send(OP_SET, 1, 16'h0302, 16'd64, 64'h5E7);
        send(OP_SET, 0, 16'h0303, 16'd64, 64'h5E8);
        send(OP_DEL, 0, 16'h0304, 16'd0, 64'hDE1);
        send(OP_GET, 1, 16'hFFFE, 16'd200, 64'hFFFE);
        wait_idle();

        tmode = 0;
        val_seen = 0;
        send(OP_GET, 1, 16'h0400, 16'd130, 64'h4000);
        n = 0;
        while (val_seen < 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reset_wait", val_seen >= 1, 1'b1);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        #2;
        check("mid_rst_tvalid", bus.m_axis_tvalid, 1'b0);
        check("mid_rst_rd_valid", bus.m_rd_valid, 1'b0);
        check("mid_rst_free_valid", bus.m_free_pointer_valid, 1'b0);
        check("mid_rst_result_ready", bus.s_result_ready, 1'b1);
        check("mid_rst_state", dut.state, ST_IDLE);
        clear_model();
        rst = 1'b0;
        send(OP_GET, 1, 16'h0500, 16'd70, 64'h5000);
        wait_idle();

        tmode = 2;
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 9);
            logic [15:0] len = r == 0 ? 16'd0 : r == 1 ? 16'(4096 + $urandom_range(1, 200)) :
                               r == 2 ? 16'($urandom_range(1, 64)) : 16'($urandom_range(1, 1500));
            logic [15:0] p = $urandom_range(0, 7) == 0 ? 16'hFFFD : 16'($urandom);
            send(8'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, p, len, {$urandom, $urandom});
        end
        wait_idle();
        check("leftover_reads", exp_rd.size(), 0);
        check("leftover_outstanding", outstanding, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/kv_response_builder.md
Name: kv_response_builder

Overview:
- Transmit-side back end of the UDP KV shell and counterpart of the request front end.
- Consumes one lookup/insert result per request and, for GET hits, reads the value boxes (one box = 512 bits) from value memory by pointer.
- Emits the response packet on a 512-bit AXI-Stream towards the UDP TX path.
- Returns the pointers of deleted entries to the allocator's free-pointer stream.

Parameters:
- DATA_WIDTH, 512, stream and memory box width in bits; the design supports only 512.
- PTR_WIDTH, 16, value-memory box pointer width.
- MAX_BEATS, 64, largest value in boxes (4096 B).
- MAX_OUTSTANDING, 4, in-flight memory reads; equals the read-data FIFO depth.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset. This is fixed: one clock, synchronous active-high reset.
- s_result_data  in  105  {op[104:97], hit[96], ptr[95:80], len_bytes[79:64], key[63:0]}.
- s_result_valid  in  1  result handshake.
- s_result_ready  out  1  result handshake.
- m_rd_addr  out  16  box address to value memory.
- m_rd_valid  out  1  read-request handshake.
- m_rd_ready  in  1  read-request handshake.
- s_rd_data  in  512  read data; returns in request order.
- s_rd_valid  in  1  read-data handshake.
- s_rd_ready  out  1  read-data handshake.
- m_axis_tdata  out  512  response stream.
- m_axis_tvalid  out  1  response stream.
- m_axis_tlast  out  1  response stream.
- m_axis_tkeep  out  64  response stream.
- m_axis_tready  in  1  response stream.
- m_free_pointer  out  16  freed pointer.
- m_free_pointer_valid  out  1  freed-pointer handshake.
- m_free_pointer_ready  in  1  freed-pointer handshake.

Behaviour:
- Reset: every valid output is 0, data/keep/addr are 0, FSM goes to ST_IDLE, counters clear. An in-flight packet is dropped without a tlast.
- s_result_ready is 1 only in ST_IDLE. A result is captured on the handshake.
- nbeats = (len_bytes+63)>>6, computed 17 bits wide.
- Header beat fields:
  - [63:0] key.
  - [79:64] len_bytes; forced to 0 unless a GET hit.
  - [87:80] op.
  - [95:88] status: 0 OK, 1 MISS, 2 TOOBIG.
  - All other bits 0.
- Cases:
  - GET hit with 0 < nbeats <= MAX_BEATS: header beat (tkeep all ones, tlast 0), then nbeats value beats.
  - GET hit with len 0: header only.
  - GET hit with nbeats > MAX_BEATS: status TOOBIG, header only, no reads.
  - Miss, any op: status MISS, header only.
  - SET: status OK, header only.
  - DEL hit: header only, then ptr pushed on the free stream.
- Header-only beat: tlast 1, tkeep 64'h0FFF (12 bytes).
- Last value beat: tkeep = low (len_bytes mod 64) bytes set, all ones if the remainder is 0; tlast 1.
- FSM states:
  - ST_IDLE: on accept go to ST_HDR.
  - ST_HDR: hold header until tready. Then go to ST_DATA if a GET hit with value, ST_FREE if a DEL hit, else ST_IDLE.
  - ST_DATA: read issue runs in parallel from header accept. m_rd_addr = ptr+issued (16-bit wrap allowed); issue while issued<nbeats and credits>0.
    - Credit counter starts at MAX_OUTSTANDING.
    - Credit decrements on a read handshake and increments on a FIFO pop; a simultaneous request and pop leaves it unchanged.
    - Read data enters the shared fifo (depth MAX_OUTSTANDING). The FIFO head drives m_axis; pop on tvalid&&tready.
    - After sent==nbeats, return to ST_IDLE.
  - ST_FREE: hold m_free_pointer_valid until ready, then return to ST_IDLE.
- AXIS rules: payload is stable while tvalid&&!tready. No bubbles are inserted while FIFO data is available.
- Latency: header is valid 1 cycle after the result handshake. The first read request is issued the cycle after header acceptance.

Optional Feature:
- Macro: KV_RESP_TIMESTAMP_EN.
- With the macro: a free-running 32-bit cycle counter (reset 0, wraps) is sampled at result accept and placed in header [127:96]. Header-only tkeep becomes 64'hFFFF.
- Without the macro: header [127:96] is 0, tkeep is as above, and no counter is synthesised.

Decomposition:
- Package kv_pkg holds:
  - Opcodes OP_GET=0, OP_SET=1, OP_DEL=2.
  - Status codes.
  - RESULT_W=105 and result field offsets.
  - Header field offsets.
  - A tkeep-from-remainder function.
- Read data buffering reuses the existing fifo module. No new sub-module is created.

Test Plan:
- GET hit, ptr=0x0010, len=130, tready=1:
  - Header carries len 130 and status 0.
  - Reads go to addresses 0x10, 0x11, 0x12.
  - 3 value beats follow; last tkeep=64'h3, tlast on beat 4.
- GET miss, key=0xDEADBEEF: single beat, status 1, len field 0, tkeep 64'h0FFF, tlast 1; no m_rd_valid.
- DEL hit, ptr=0x0042, with m_free_pointer_ready held 0 for 5 cycles: header sent, then m_free_pointer=0x0042 held valid until ready; s_result_ready stays 0 until then.
- GET hit, len=4096, m_axis_tready toggling 1/0 every cycle:
  - 64 value beats arrive intact and in order.
  - Outstanding reads never exceed 4; no FIFO overflow.
  - Last tkeep is all ones.
- GET hit, len=4097 -> status 2, header only, zero reads.
- Reset asserted mid-packet at value beat 2 of 3 -> next cycle all valids are 0, FSM is in ST_IDLE, s_result_ready is 1, and a new GET completes correctly.
